// File: rtl/addsub_pkg.sv
// Shared constants and helpers for the pipelined adder/subtractor.
package addsub_pkg;

  // Operation select on the m input.
  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  // Bit positions of the status flags inside the packed flag register.
  localparam int FLAG_C = 0;
  localparam int FLAG_V = 1;
  localparam int FLAG_Z = 2;
  localparam int FLAG_N = 3;

  // One pipeline stage per CHUNK-bit slice of the carry chain.
  function automatic int calc_stages(input int width, input int chunk);
    return width / chunk;
  endfunction

endpackage

// File: rtl/addsub_slice.sv
// Combinational CHUNK-bit ripple-carry slice.
// cmsb is the carry into the slice MSB, needed for signed overflow detection.
module addsub_slice #(
  parameter int CHUNK = 2
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             cmsb
);

  logic [CHUNK:0] cc;

  // Ripple the carry through the slice one bit at a time.
  always_comb begin
    cc    = '0;
    sum   = '0;
    cc[0] = cin;
    for (int i = 0; i < CHUNK; i++) begin
      sum[i]   = x[i] ^ y[i] ^ cc[i];
      cc[i+1]  = (x[i] & y[i]) | (cc[i] & (x[i] ^ y[i]));
    end
  end

  assign cout = cc[CHUNK];
  assign cmsb = cc[CHUNK-1];

endmodule

// File: rtl/addsub_pipe.sv
// Pipelined two's-complement adder/subtractor with valid/ready handshake.
// Each stage resolves one CHUNK-bit slice of the carry chain; the last stage
// is the output register and also holds the registered status flags.
module addsub_pipe
  import addsub_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             m,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             c,
  output logic             v,
  output logic             z,
  output logic             n
);

  localparam int STAGES = calc_stages(WIDTH, CHUNK);
  localparam int L      = STAGES - 1;

  // Reject geometries the slicing cannot express.
  if ((WIDTH % CHUNK) != 0 || WIDTH < 2) begin : g_bad_params
    $error("addsub_pipe: WIDTH must be >= 2 and a multiple of CHUNK");
  end

  logic                          advance;
  logic                          sub;
  logic [STAGES-1:0]             vld_in;
  logic [STAGES-1:0]             vld_q;
  logic [STAGES-1:0][WIDTH-1:0]  x_d, x_q;
  logic [STAGES-1:0][WIDTH-1:0]  y_d, y_q;
  logic [STAGES-1:0]             cy_d, cy_q;
  logic [STAGES-1:0]             cm_d;
  logic [3:0]                    flg_d, flg_q;

  // Global enable: the whole pipe moves unless the head result is blocked.
  assign advance  = !vld_q[L] || out_ready;
  assign in_ready = advance;
  assign sub      = (m == MODE_SUB);

  // x carries resolved sum bits below the current slice and operand A above;
  // y carries the (possibly inverted) operand B; cy is the inter-slice carry.
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [WIDTH-1:0] xp, yp, xn;
    logic             cin;
    logic [CHUNK-1:0] sum;
    logic             cout, cmsb;

    if (k == 0) begin : g_first
      assign xp        = a;
      assign yp        = b ^ {WIDTH{sub}};
      assign cin       = sub;
      assign vld_in[k] = in_valid;
    end else begin : g_next
      assign xp        = x_q[k-1];
      assign yp        = y_q[k-1];
      assign cin       = cy_q[k-1];
      assign vld_in[k] = vld_q[k-1];
    end

    addsub_slice #(.CHUNK(CHUNK)) u_slice (
      .x    (xp[k*CHUNK +: CHUNK]),
      .y    (yp[k*CHUNK +: CHUNK]),
      .cin  (cin),
      .sum  (sum),
      .cout (cout),
      .cmsb (cmsb)
    );

    // Splice this slice's sum bits into the pass-through vector.
    always_comb begin
      xn                     = xp;
      xn[k*CHUNK +: CHUNK]   = sum;
    end

    assign x_d[k]  = xn;
    assign y_d[k]  = yp;
    assign cy_d[k] = cout;
    assign cm_d[k] = cmsb;
  end

  // Flags are derived from the final slice before being registered with s.
  always_comb begin
    flg_d         = '0;
    flg_d[FLAG_C] = cy_d[L];
    flg_d[FLAG_V] = cm_d[L] ^ cy_d[L];
    flg_d[FLAG_Z] = (x_d[L] == '0);
    flg_d[FLAG_N] = x_d[L][WIDTH-1];
  end

  // Pipeline registers: valid bits shift on advance; data loads only with valid,
  // so s and the flags hold while bubbles pass through.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      x_q   <= '0;
      y_q   <= '0;
      cy_q  <= '0;
      flg_q <= '0;
    end else if (advance) begin
      vld_q <= vld_in;
      for (int k = 0; k < STAGES; k++) begin
        if (vld_in[k]) begin
          x_q[k]  <= x_d[k];
          y_q[k]  <= y_d[k];
          cy_q[k] <= cy_d[k];
        end
      end
      if (vld_in[L]) begin
        flg_q <= flg_d;
      end
    end
  end

  assign out_valid = vld_q[L];
  assign s         = x_q[L];
  assign c         = flg_q[FLAG_C];
  assign v         = flg_q[FLAG_V];
  assign z         = flg_q[FLAG_Z];
  assign n         = flg_q[FLAG_N];

  // Consumed operand bits and the final-stage carry register have no reader.
  logic unused_sink;
  assign unused_sink = ^{y_q, cy_q, cm_d};

endmodule

// File: tb/tb_addsub_pipe.sv
// Bench for addsub_pipe: three instances (CHUNK = 2, 8, 1 at WIDTH = 8) share
// one stimulus stream; each has its own expected-result queue.
module tb_addsub_pipe;

  localparam int NDUT = 3;

  logic       clk       = 1'b0;
  logic       rst       = 1'b1;
  logic       in_valid  = 1'b0;
  logic       m         = 1'b0;
  logic       out_ready = 1'b1;
  logic [7:0] a         = 8'h00;
  logic [7:0] b         = 8'h00;
  logic       drain_chk = 1'b0;

  logic       ir_w [NDUT];
  logic       ov_w [NDUT];
  logic [7:0] s_w  [NDUT];
  logic       c_w  [NDUT];
  logic       v_w  [NDUT];
  logic       z_w  [NDUT];
  logic       n_w  [NDUT];
  int         outs_w [NDUT];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  task automatic chk(input string name, input int tag, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (chunk %0d): got 0x%0h, expected 0x%0h", name, tag, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic, result packed as {s, c, v, z, n}.
  function automatic logic [11:0] model(input logic [7:0] av, input logic [7:0] bv,
                                        input logic mv);
    int ua, ub, sa, sb, ur, sr;
    logic [7:0] sv;
    logic cv, vv;
    ua = int'(av);
    ub = int'(bv);
    sa = int'($signed(av));
    sb = int'($signed(bv));
    if (mv) begin
      ur = ua - ub;
      sr = sa - sb;
      cv = (ua >= ub);
    end else begin
      ur = ua + ub;
      sr = sa + sb;
      cv = (ur > 255);
    end
    vv = (sr < -128) || (sr > 127);
    sv = 8'(ur & 255);
    return {sv, cv, vv, (sv == 8'h00), sv[7]};
  endfunction

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    localparam int CH = (g == 0) ? 2 : ((g == 1) ? 8 : 1);

    addsub_pipe #(.WIDTH(8), .CHUNK(CH)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (ir_w[g]),
      .a         (a),
      .b         (b),
      .m         (m),
      .out_valid (ov_w[g]),
      .out_ready (out_ready),
      .s         (s_w[g]),
      .c         (c_w[g]),
      .v         (v_w[g]),
      .z         (z_w[g]),
      .n         (n_w[g])
    );

    logic [11:0] q [$];
    logic        prev_stall = 1'b0;

    initial outs_w[g] = 0;

    always @(posedge rst) begin
      q.delete();
      prev_stall = 1'b0;
    end

    // Compare on the falling edge, where inputs and outputs are stable.
    always @(negedge clk) begin
      if (!rst) begin
        chk("in_ready", CH, 32'(ir_w[g]), 32'(!ov_w[g] || out_ready));
        if (prev_stall) chk("hold_valid", CH, 32'(ov_w[g]), 32'(1));
        if (ov_w[g]) begin
          if (q.size() == 0) begin
            chk("spurious_out", CH, 32'(q.size()), 32'(1));
          end else begin
            chk("result", CH, 32'({s_w[g], c_w[g], v_w[g], z_w[g], n_w[g]}), 32'(q[0]));
            if (out_ready) begin
              void'(q.pop_front());
              outs_w[g]++;
            end
          end
        end
        if (in_valid && ir_w[g]) q.push_back(model(a, b, m));
        prev_stall = ov_w[g] && !out_ready;
      end
    end

    always @(posedge drain_chk) chk("drained", CH, 32'(q.size()), 32'(0));
  end

  // Single op on an idle pipe with out_ready high; checks exact latency of the
  // 1-stage and 4-stage instances against a hand-computed result.
  task automatic do_op(input string name, input logic [7:0] av, input logic [7:0] bv,
                       input logic mv, input logic [11:0] exp);
    a = av; b = bv; m = mv; in_valid = 1'b1;
    chk({name, "_model"}, 0, 32'(model(av, bv, mv)), 32'(exp));
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk({name, "_lat1"}, 8, 32'({ov_w[1], s_w[1], c_w[1], v_w[1], z_w[1], n_w[1]}),
        32'({1'b1, exp}));
    @(posedge clk); @(posedge clk); #1;
    chk({name, "_early"}, 2, 32'(ov_w[0]), 32'(0));
    @(posedge clk); #1;
    chk({name, "_lat4"}, 2, 32'({ov_w[0], s_w[0], c_w[0], v_w[0], z_w[0], n_w[0]}),
        32'({1'b1, exp}));
  endtask

  function automatic logic [7:0] pick();
    case ($urandom_range(0, 7))
      0: return 8'h00;
      1: return 8'h7F;
      2: return 8'h80;
      3: return 8'hFF;
      default: return 8'($urandom);
    endcase
  endfunction

  initial begin
    int cyc, sent, base;
    logic acc;

    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < NDUT; i++) begin
      chk("reset_out", i, 32'({ov_w[i], s_w[i], c_w[i], v_w[i], z_w[i], n_w[i]}), 32'(0));
      chk("reset_in_ready", i, 32'(ir_w[i]), 32'(1));
    end
    rst = 1'b0;
    @(posedge clk); #1;

    do_op("add",     8'h3C, 8'h15, 1'b0, 12'h510);
    do_op("sub_ovf", 8'h80, 8'h01, 1'b1, 12'h7FC);
    do_op("sub_brw", 8'h05, 8'h07, 1'b1, 12'hFE1);
    do_op("add_zc",  8'hFF, 8'h01, 1'b0, 12'h00A);
    do_op("add_ovf", 8'h7F, 8'h01, 1'b0, 12'h805);
    repeat (8) @(posedge clk); #1;

    // Six back-to-back ops with out_ready low for three cycles mid-stream.
    base = outs_w[0];
    cyc = 0; sent = 0;
    a = 8'($urandom); b = 8'($urandom); m = 1'($urandom); in_valid = 1'b1;
    while (sent < 6 && cyc < 50) begin
      out_ready = !(cyc >= 4 && cyc <= 6);
      #0;
      if (ov_w[0] && !out_ready) chk("stall_in_ready", 2, 32'(ir_w[0]), 32'(0));
      acc = ir_w[0];
      @(posedge clk); #1;
      if (acc) begin
        sent++;
        a = 8'($urandom); b = 8'($urandom); m = 1'($urandom);
      end
      cyc++;
    end
    if (sent < 6) chk("stream_budget", 2, 32'(sent), 32'(6));
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (12) @(posedge clk); #1;
    chk("stream_count", 2, 32'(outs_w[0] - base), 32'(6));

    // Reset with three ops in flight, the first already at the output.
    for (int i = 0; i < 3; i++) begin
      a = 8'($urandom); b = 8'($urandom); m = 1'($urandom); in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("pre_reset_valid", 2, 32'(ov_w[0]), 32'(1));
    #1 rst = 1'b1;
    #1;
    for (int i = 0; i < NDUT; i++)
      chk("async_reset", i, 32'({ov_w[i], s_w[i]}), 32'(0));
    #1 rst = 1'b0;
    do_op("post_reset", 8'h01, 8'h01, 1'b0, 12'h020);
    repeat (8) @(posedge clk); #1;

    // Random stream with random backpressure.
    for (int i = 0; i < 10000; i++) begin
      in_valid  = ($urandom_range(0, 99) < 70);
      out_ready = ($urandom_range(0, 99) < 70);
      a = pick(); b = pick(); m = 1'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (12) @(posedge clk); #1;
    drain_chk = 1'b1;
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
